// File: rtl/conv_window_gen.sv
// Streaming KERNEL x KERNEL x CL_IN sliding-window generator feeding the convolution engine.
// Optional build macro CONV_WINDOW_GEN_STRIDE2_EN restricts output to windows at even top-left row/column.
module conv_window_gen #(
  parameter int CL_IN  = 9,
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [CL_IN*N-1:0]               d_in,
  input  logic                             en_in,
  output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
  output logic                             en_out,
  output logic                             frame_end
);

  localparam int PIX_W = CL_IN * N;
  localparam int WIN_W = CL_IN * KERNEL * KERNEL * N;
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
  localparam int LAST_ROW = ((IMG_H - KERNEL) / 2) * 2 + KERNEL - 1;
  localparam int LAST_COL = ((IMG_W - KERNEL) / 2) * 2 + KERNEL - 1;
`else
  localparam int LAST_ROW = IMG_H - 1;
  localparam int LAST_COL = IMG_W - 1;
`endif

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             accept;
  logic             emit_p0;
  logic             last_p0;
  logic [PIX_W-1:0] win_p0 [KERNEL][KERNEL];
  logic [WIN_W-1:0] win_flat_p0;

  // A pixel presented during reset is dropped everywhere, including the line buffers.
  assign accept = en_in & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (en_in) begin
      if (col == CW'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_comb begin
    emit_p0 = (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1));
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
    // Top-left corner parity equals bottom-right parity shifted by KERNEL-1.
    emit_p0 = emit_p0 && (row[0] == 1'(KERNEL - 1)) && (col[0] == 1'(KERNEL - 1));
`endif
    last_p0 = (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));
  end

  // ---- stage p0: line buffers and window assembly ----
  if (KERNEL > 1) begin : g_lines
    localparam int LB_LEN = (KERNEL - 1) * IMG_W;
    logic [PIX_W-1:0] lb   [LB_LEN];
    logic [PIX_W-1:0] hold [KERNEL][KERNEL-1];

    // lb[m*IMG_W-1] is the pixel m rows above the incoming one, same column.
    always_comb begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL - 1; k++) begin
          win_p0[r][k] = hold[r][k];
        end
      end
      for (int r = 0; r < KERNEL - 1; r++) begin
        win_p0[r][KERNEL-1] = lb[(KERNEL - 1 - r) * IMG_W - 1];
      end
      win_p0[KERNEL-1][KERNEL-1] = d_in;
    end

    always_ff @(posedge clk) begin
      if (accept) begin
        lb[0] <= d_in;
        for (int i = 1; i < LB_LEN; i++) begin
          lb[i] <= lb[i-1];
        end
        for (int r = 0; r < KERNEL; r++) begin
          for (int k = 0; k < KERNEL - 1; k++) begin
            hold[r][k] <= win_p0[r][k+1];
          end
        end
      end
    end
  end else begin : g_single
    always_comb begin
      win_p0[0][0] = d_in;
    end
  end

  always_comb begin
    win_flat_p0 = '0;
    for (int c = 0; c < CL_IN; c++) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int k = 0; k < KERNEL; k++) begin
          win_flat_p0[(c*KERNEL*KERNEL + r*KERNEL + k)*N +: N] = win_p0[r][k][c*N +: N];
        end
      end
    end
  end

  // ---- stage p1: registered window and strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data2conv <= '0;
      en_out    <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      en_out    <= accept && emit_p0;
      frame_end <= accept && emit_p0 && last_p0;
      if (accept && emit_p0) begin
        data2conv <= win_flat_p0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed-sequence bench for conv_window_gen: default 3x3 instance plus a KERNEL=1 4x4 instance,
// both compared cycle by cycle against a frame-array reference model.
module tb_conv_window_gen;

  localparam int CL_IN  = 9;
  localparam int KERNEL = 3;
  localparam int N      = 4;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int PIX_W  = CL_IN * N;
  localparam int WIN_W  = CL_IN * KERNEL * KERNEL * N;
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
  localparam int EXP_PULSES = ((IMG_H - KERNEL + 2) / 2) * ((IMG_W - KERNEL + 2) / 2);
`else
  localparam int EXP_PULSES = (IMG_H - KERNEL + 1) * (IMG_W - KERNEL + 1);
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en_in;
  logic [PIX_W-1:0] d_in;
  logic [WIN_W-1:0] data2conv;
  logic             en_out;
  logic             frame_end;
  logic [PIX_W-1:0] data2conv_k1;
  logic             en_out_k1;
  logic             frame_end_k1;

  always #5 clk = ~clk;

  conv_window_gen #(.CL_IN(CL_IN), .KERNEL(KERNEL), .N(N), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .data2conv(data2conv), .en_out(en_out), .frame_end(frame_end)
  );

  conv_window_gen #(.CL_IN(CL_IN), .KERNEL(1), .N(N), .IMG_W(4), .IMG_H(4)) dut_k1 (
    .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in),
    .data2conv(data2conv_k1), .en_out(en_out_k1), .frame_end(frame_end_k1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: whole frame image, pixel indices, expected outputs.
  logic [PIX_W-1:0] img [IMG_H][IMG_W];
  int               p = 0;
  int               p1 = 0;
  logic [WIN_W-1:0] exp_data = '0;
  logic             exp_en = 1'b0;
  logic             exp_fe = 1'b0;
  logic [PIX_W-1:0] exp_data1 = '0;
  logic             exp_en1 = 1'b0;
  logic             exp_fe1 = 1'b0;
  int               pulses, fe_pulses, accepted, first_at;

  function automatic bit is_emit(int r, int c, int k);
    bit e;
    e = (r >= k - 1) && (c >= k - 1);
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
    e = e && ((r - k + 1) % 2 == 0) && ((c - k + 1) % 2 == 0);
`endif
    return e;
  endfunction

  function automatic bit is_last(int r, int c, int k, int w, int h);
    if (!is_emit(r, c, k)) return 1'b0;
    for (int q = r * w + c + 1; q < w * h; q++) begin
      if (is_emit(q / w, q % w, k)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [WIN_W-1:0] window_at(int row, int col);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int c = 0; c < CL_IN; c++)
      for (int r = 0; r < KERNEL; r++)
        for (int k = 0; k < KERNEL; k++)
          w[(c*KERNEL*KERNEL + r*KERNEL + k)*N +: N] = img[row-KERNEL+1+r][col-KERNEL+1+k][c*N +: N];
    return w;
  endfunction

  function automatic logic [PIX_W-1:0] pattern_pix(int q);
    logic [PIX_W-1:0] v;
    int val;
    val = ((q / IMG_W) * 8 + q % IMG_W) % 16;
    for (int c = 0; c < CL_IN; c++) v[c*N +: N] = N'(val);
    return v;
  endfunction

  function automatic logic [PIX_W-1:0] rnd();
    return PIX_W'({$urandom(), $urandom()});
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_win(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r_i, input logic en_i, input logic [PIX_W-1:0] d_i);
    int row, col;
    rst = r_i;
    en_in = en_i;
    d_in = d_i;
    @(posedge clk);
    #1;
    if (r_i) begin
      exp_en = 1'b0; exp_fe = 1'b0; exp_data = '0; p = 0;
      exp_en1 = 1'b0; exp_fe1 = 1'b0; exp_data1 = '0; p1 = 0;
    end else if (en_i) begin
      accepted++;
      row = p / IMG_W;
      col = p % IMG_W;
      img[row][col] = d_i;
      exp_en = is_emit(row, col, KERNEL);
      exp_fe = is_last(row, col, KERNEL, IMG_W, IMG_H);
      if (exp_en) exp_data = window_at(row, col);
      p = (p + 1) % (IMG_W * IMG_H);
      exp_en1 = is_emit(p1 / 4, p1 % 4, 1);
      exp_fe1 = is_last(p1 / 4, p1 % 4, 1, 4, 4);
      if (exp_en1) exp_data1 = d_i;
      p1 = (p1 + 1) % 16;
    end else begin
      exp_en = 1'b0; exp_fe = 1'b0; exp_en1 = 1'b0; exp_fe1 = 1'b0;
    end
    if (en_out) pulses++;
    if (frame_end) fe_pulses++;
    if (en_out && first_at < 0) first_at = accepted;
    check_bit("en_out", en_out, exp_en);
    check_bit("frame_end", frame_end, exp_fe);
    check_win("data2conv", data2conv, exp_data);
    check_bit("k1 en_out", en_out_k1, exp_en1);
    check_bit("k1 frame_end", frame_end_k1, exp_fe1);
    check_win("k1 data2conv", WIN_W'(data2conv_k1), WIN_W'(exp_data1));
  endtask

  task automatic start_frame();
    pulses = 0; fe_pulses = 0; accepted = 0; first_at = -1;
  endtask

  task automatic end_frame(input string tag);
    check_int({tag, " pulse count"}, pulses, EXP_PULSES);
    check_int({tag, " frame_end count"}, fe_pulses, 1);
    check_int({tag, " first en_out pixel"}, first_at, 19);
  endtask

  // mode 0: continuous, 1: en_in toggled every cycle, 2: random gaps
  task automatic run_frame(input int mode, input bit use_pattern, input int npix);
    logic [PIX_W-1:0] d;
    for (int i = 0; i < npix; i++) begin
      d = use_pattern ? pattern_pix(p) : rnd();
      if (mode == 2) repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, rnd());
      step(1'b0, 1'b1, d);
      if (mode == 1) step(1'b0, 1'b0, rnd());
    end
  endtask

  int exp0 [9] = '{0, 1, 2, 8, 9, 10, 0, 1, 2};

  initial begin
    rst = 1'b1;
    en_in = 1'b0;
    d_in = '0;
    start_frame();
    step(1'b1, 1'b1, rnd());
    step(1'b1, 1'b0, '0);

    // Frame 1: ramp pattern, continuous, with explicit first-window contents.
    start_frame();
    for (int i = 0; i < IMG_W * IMG_H; i++) begin
      step(1'b0, 1'b1, pattern_pix(p));
      if (i == 18) begin
        check_bit("first window strobe", en_out, 1'b1);
        for (int j = 0; j < 9; j++) check_int("first window ch0", int'(data2conv[j*N +: N]), exp0[j]);
      end
    end
    end_frame("f1");

    // Frame 2 back-to-back: same pattern, en_in toggling.
    start_frame();
    run_frame(1, 1'b1, IMG_W * IMG_H);
    end_frame("f2");

    // Frame 3: random data, random gaps.
    start_frame();
    run_frame(2, 1'b0, IMG_W * IMG_H);
    end_frame("f3");

    // Partial frame through pixel (4,5), reset one cycle with en_in high, then restart.
    start_frame();
    run_frame(0, 1'b0, 4 * IMG_W + 6);
    step(1'b1, 1'b1, rnd());
    start_frame();
    run_frame(0, 1'b0, IMG_W * IMG_H);
    end_frame("after rst");

    // Final random frame with gaps and pattern data.
    start_frame();
    run_frame(2, 1'b1, IMG_W * IMG_H);
    end_frame("f5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator that sits directly upstream of the convolution engine (CE).
- Accepts one pixel per enabled cycle: all CL_IN channels at once, in raster order.
- Buffers KERNEL-1 previous image rows and emits a full KERNEL x KERNEL x CL_IN window, in exactly the packed format of CE's data2conv input, with a one-cycle strobe that drives CE's en_in.
- Valid-mode convolution only; no padding.

Parameters:
- CL_IN, 9, number of input feature channels (3..64)
- KERNEL, 3, window edge size (1/3/5/7)
- N, 4, data width per channel sample
- IMG_W, 8, image width in pixels (>= KERNEL)
- IMG_H, 8, image height in pixels (>= KERNEL)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- d_in  in  CL_IN*N  one pixel; channel c at bits [c*N +: N]
- en_in  in  1  d_in valid; pixel accepted on this edge
- data2conv  out  CL_IN*KERNEL*KERNEL*N  packed window, registered
- en_out  out  1  data2conv valid, one-cycle pulse
- frame_end  out  1  one-cycle pulse, coincides with the window containing the last pixel of the frame

Behaviour:
- Reset (synchronous, active-high):
  - data2conv = 0, en_out = 0, frame_end = 0.
  - Column and row counters = 0.
  - Line-buffer contents need not be cleared; they are gated by the row counter.
- Counters:
  - col counts 0..IMG_W-1 on each accepted pixel.
  - On wrap, col returns to 0 and row increments.
  - row wraps 0 after IMG_H-1, so frames run back-to-back.
- No backpressure. en_in may have gaps of any length; all state holds while en_in = 0.
- Line buffers:
  - KERNEL-1 rows of IMG_W pixels each (CL_IN*N bits per pixel).
  - Shifted only on an accepted pixel.
- Window register:
  - KERNEL x KERNEL pixels.
  - On each accepted pixel, columns shift left and the new column is loaded.
  - New column = {line buffers (oldest row at top), d_in}.
- Packing of data2conv:
  - Index i = c*KERNEL*KERNEL + r*KERNEL + k, occupying bits [i*N +: N].
  - c = channel; r = window row (0 = top, oldest row); k = window column (0 = leftmost, oldest).
- Valid condition and latency:
  - Pixel accepted at (row, col) with row >= KERNEL-1 and col >= KERNEL-1 causes en_out = 1 on the next cycle.
  - data2conv then holds rows row-KERNEL+1..row and columns col-KERNEL+1..col.
  - Latency is 1 cycle from the accepting edge.
- data2conv updates only when en_out asserts; it holds its last value otherwise.
- Row boundary:
  - Windows never straddle rows; col < KERNEL-1 suppresses en_out.
  - The window register needs no flush because the first valid window of each row has fully reloaded it.
- Frame boundary:
  - Rows 0..KERNEL-2 of a new frame suppress en_out, so stale line-buffer data never reaches the output.
- Output count: (IMG_H-KERNEL+1)*(IMG_W-KERNEL+1) en_out pulses per frame.
- frame_end = 1 in the same cycle as the en_out for pixel (IMG_H-1, IMG_W-1).
- KERNEL = 1: no line buffers; data2conv = registered d_in; en_out on every accepted pixel.
- rst mid-frame: the next accepted pixel is treated as (0,0), and no en_out occurs until (KERNEL-1, KERNEL-1).
- en_in = 1 during rst: the pixel is discarded.

Optional Feature:
- Macro: CONV_WINDOW_GEN_STRIDE2_EN.
- Defined:
  - en_out (and the data2conv update) is restricted to windows whose top-left row and column are both even.
  - Count per frame = ceil((IMG_H-KERNEL+1)/2) * ceil((IMG_W-KERNEL+1)/2).
  - frame_end pulses on the last emitted window of the frame.
- Undefined: stride 1 as described in Behaviour.

Test Plan:
- Defaults; all channels of pixel (r,c) = (r*8+c) mod 16; en_in continuous.
  - First en_out one cycle after pixel (2,2), i.e. the 19th accepted pixel.
  - Channel 0 window values = 0,1,2 / 8,9,10 / 0,1,2 (rows 0..2).
  - Exactly 36 en_out pulses per frame.
- Same stimulus, en_in toggled 1/0 every cycle → identical window values and count; each en_out comes one cycle after its accepting edge.
- Two back-to-back frames → second frame's first en_out only after its pixel (2,2); no window contains frame-1 rows; frame_end pulses exactly twice, each with the 36th window.
- rst asserted for 1 cycle after pixel (4,5) → outputs 0 the following cycle; restarting from (0,0), the first en_out again follows the 19th pixel.
- KERNEL=1, IMG_W=IMG_H=4 → en_out follows every pixel with 1-cycle latency; data2conv = the prior d_in; 16 pulses per frame.
- CONV_WINDOW_GEN_STRIDE2_EN defined, defaults → 9 en_out pulses per frame, top-left corners (0,0),(0,2),(0,4),(2,0)..(4,4); frame_end with window (4,4).
